// File: rtl/ram_dump_uart.sv
// Reads RAM words 0..2**ADDR_WIDTH-1 while the CPU is halted and sends each one as an 8N1 UART frame.
// Optional macro RAM_DUMP_CHECKSUM_EN appends one frame carrying the mod-2**DATA_WIDTH sum of the dumped words.
module ram_dump_uart #(
   parameter int CLK_DIV    = 234,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  cpu_halted,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_rd_en,
   input  logic [DATA_WIDTH-1:0] ram_data,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0]         CNT_MAX  = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0]         BIT_MAX  = BW'(DATA_WIDTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    tx_q, tx_d;
   logic                    baud_end;

`ifdef RAM_DUMP_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]   sum_q, sum_d;
   logic                    chk_q, chk_d;
`endif

   assign baud_end = (cnt_q == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         addr_q  <= '0;
         tx_q    <= 1'b1;
`ifdef RAM_DUMP_CHECKSUM_EN
         sum_q   <= '0;
         chk_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         addr_q  <= addr_d;
         tx_q    <= tx_d;
`ifdef RAM_DUMP_CHECKSUM_EN
         sum_q   <= sum_d;
         chk_q   <= chk_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      addr_d  = addr_q;
`ifdef RAM_DUMP_CHECKSUM_EN
      sum_d   = sum_q;
      chk_d   = chk_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start && cpu_halted) begin
               state_d = S_READ;
               addr_d  = '0;
`ifdef RAM_DUMP_CHECKSUM_EN
               sum_d   = '0;
               chk_d   = 1'b0;
`endif
            end
         end
         S_READ: state_d = S_WAIT;
         S_WAIT: begin
`ifdef RAM_DUMP_CHECKSUM_EN
            // the checksum frame reuses READ/WAIT for timing but loads the sum instead of RAM data
            if (chk_q) begin
               shift_d = sum_q;
            end else begin
               shift_d = ram_data;
               sum_d   = sum_q + ram_data;
            end
`else
            shift_d = ram_data;
`endif
            cnt_d   = '0;
            state_d = S_START;
         end
         S_START: begin
            if (baud_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_MAX) begin
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               cnt_d = '0;
`ifdef RAM_DUMP_CHECKSUM_EN
               if (chk_q) begin
                  state_d = S_DONE;
               end else if (addr_q == ADDR_MAX) begin
                  chk_d   = 1'b1;
                  state_d = S_READ;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = S_READ;
               end
`else
               if (addr_q == ADDR_MAX) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = S_READ;
               end
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // tx is registered from the current state, so the line lags the state by one cycle
   always_comb begin
      tx_d      = 1'b1;
      busy      = 1'b0;
      done      = 1'b0;
      ram_rd_en = 1'b0;
      case (state_q)
         S_READ: begin
            busy      = 1'b1;
`ifdef RAM_DUMP_CHECKSUM_EN
            ram_rd_en = !chk_q;
`else
            ram_rd_en = 1'b1;
`endif
         end
         S_WAIT:  busy = 1'b1;
         S_START: begin
            busy = 1'b1;
            tx_d = 1'b0;
         end
         S_DATA: begin
            busy = 1'b1;
            tx_d = shift_q[0];
         end
         S_STOP:  busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign tx       = tx_q;
   assign ram_addr = addr_q;

endmodule

// File: tb/tb_ram_dump_uart.sv
// Directed bench for ram_dump_uart at CLK_DIV=4: timing, decoded frames, halt gating, async reset, back-to-back dumps.
// Cycle n below means "observed on the falling edge after rising edge n", edge 0 being the one that samples start.
module tb_ram_dump_uart;

   localparam int DIV      = 4;
   localparam int BYTE_CYC = 2 + 10 * DIV;
`ifdef RAM_DUMP_CHECKSUM_EN
   localparam int NFR      = 17;
`else
   localparam int NFR      = 16;
`endif
   localparam int DUMP_LEN = NFR * BYTE_CYC;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       cpu_halted;
   logic [3:0] ram_addr;
   logic       ram_rd_en;
   logic [7:0] ram_data;
   logic       tx;
   logic       busy;
   logic       done;

   logic [7:0] mem [16];

   int n_vec;
   int n_err;

   ram_dump_uart #(
      .CLK_DIV(DIV),
      .ADDR_WIDTH(4),
      .DATA_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .cpu_halted(cpu_halted),
      .ram_addr(ram_addr),
      .ram_rd_en(ram_rd_en),
      .ram_data(ram_data),
      .tx(tx),
      .busy(busy),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_rd_en) ram_data <= mem[ram_addr];
   end

   // UART receiver: frame bit j sampled mid-bit, frame[0] = start bit, frame[9] = stop bit
   logic [9:0] frames [$];
   logic [9:0] fbits;
   logic       dact;
   int         dpos;

   initial begin
      dact  = 1'b0;
      dpos  = 0;
      fbits = '0;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         dact = 1'b0;
      end else begin
         if (!dact) begin
            if (tx === 1'b0) begin
               dact  = 1'b1;
               dpos  = 0;
               fbits = '0;
            end
         end else begin
            dpos++;
         end
         if (dact) begin
            if (dpos % DIV == DIV / 2) fbits[dpos / DIV] = tx;
            if (dpos == 9 * DIV + DIV / 2) begin
               frames.push_back(fbits);
               dact = 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int       first_rd, first_low, done_n, done_cnt, busy_cnt, busy_last, act;
   int       rd_addrs [$];
   logic [7:0] sum;

   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      start      = 1'b0;
      cpu_halted = 1'b1;
      ram_data   = '0;
      sum        = '0;
      for (int i = 0; i < 16; i++) begin
         mem[i] = 8'(i * 8'h11);
         sum    = sum + mem[i];
      end

      // reset state
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rd_en", 32'(ram_rd_en), 32'd0);
      check("rst_addr", 32'(ram_addr), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // full dump from a one-cycle start pulse
      first_rd = -1; first_low = -1; done_n = -1;
      done_cnt = 0; busy_cnt = 0; busy_last = -1;
      frames.delete();
      rd_addrs.delete();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 0; n < DUMP_LEN + 60; n++) begin
         @(negedge clk);
         if (ram_rd_en) begin
            if (first_rd < 0) first_rd = n;
            rd_addrs.push_back(int'(ram_addr));
         end
         if (tx == 1'b0 && first_low < 0) first_low = n;
         if (done) begin
            done_cnt++;
            if (done_n < 0) done_n = n;
         end
         if (busy) begin
            busy_cnt++;
            busy_last = n;
         end
      end
      check("p1_first_rd", 32'(first_rd), 32'd0);
      check("p1_tx_fall", 32'(first_low), 32'd3);
      check("p1_done_at", 32'(done_n), 32'(DUMP_LEN));
      check("p1_done_cnt", 32'(done_cnt), 32'd1);
      check("p1_busy_cnt", 32'(busy_cnt), 32'(DUMP_LEN));
      check("p1_busy_last", 32'(busy_last), 32'(DUMP_LEN - 1));
      check("p1_rd_cnt", 32'(rd_addrs.size()), 32'd16);
      for (int i = 0; i < 16 && i < rd_addrs.size(); i++)
         check($sformatf("p1_rd_addr%0d", i), 32'(rd_addrs[i]), 32'(i));
      check("p1_frames", 32'(frames.size()), 32'(NFR));
      for (int i = 0; i < 16 && i < frames.size(); i++)
         check($sformatf("p1_frame%0d", i), 32'(frames[i]), 32'({1'b1, mem[i], 1'b0}));
`ifdef RAM_DUMP_CHECKSUM_EN
      if (frames.size() > 16) check("p1_checksum", 32'(frames[16]), 32'({1'b1, sum, 1'b0}));
`endif

      // start while CPU runs is ignored
      act = 0;
      cpu_halted = 1'b0;
      start      = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (busy || ram_rd_en || done || tx !== 1'b1) act++;
      end
      check("run_ignored", 32'(act), 32'd0);
      start      = 1'b0;
      cpu_halted = 1'b1;
      @(negedge clk);

      // start held high: A5 frame, then back-to-back second dump
      mem[0] = 8'hA5;
      frames.delete();
      done_n = -1;
      start  = 1'b1;
      @(posedge clk);
      for (int n = 0; n < DUMP_LEN + 200; n++) begin
         @(negedge clk);
         if (done) begin
            done_n = n;
            break;
         end
      end
      check("p2_done_at", 32'(done_n), 32'(DUMP_LEN));
      check("p2_a5_bits", 32'(frames.size() > 0 ? frames[0] : 10'h0), 32'h34A);
      @(negedge clk);
      check("p2_idle_gap", 32'(ram_rd_en), 32'd0);
      @(negedge clk);
      check("p2_rd_again", 32'(ram_rd_en), 32'd1);
      check("p2_rd_addr", 32'(ram_addr), 32'd0);
      start = 1'b0;

      // async reset during DATA bit 3 of byte 5 (0x55, bit 3 = 0)
      repeat (5 * BYTE_CYC + 20) @(negedge clk);
      check("b5_bit3_tx", 32'(tx), 32'd0);
      check("b5_busy", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_tx", 32'(tx), 32'd1);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_addr", 32'(ram_addr), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      act = 0;
      repeat (50) begin
         @(negedge clk);
         if (busy || ram_rd_en || done || tx !== 1'b1) act++;
      end
      check("post_rst_quiet", 32'(act), 32'd0);

      // next start dumps from address 0 again
      frames.delete();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("p3_rd_en", 32'(ram_rd_en), 32'd1);
      check("p3_addr", 32'(ram_addr), 32'd0);
      done_n = -1;
      for (int n = 1; n < DUMP_LEN + 200; n++) begin
         @(negedge clk);
         if (done) begin
            done_n = n;
            break;
         end
      end
      check("p3_done_at", 32'(done_n), 32'(DUMP_LEN));
      check("p3_frames", 32'(frames.size()), 32'(NFR));
      check("p3_byte0", 32'(frames.size() > 0 ? frames[0][8:1] : 8'h0), 32'hA5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
